// File: rtl/clock_phase_gen.sv
// Multi-channel phase clock generator: a shared phase counter drives CHANNELS
// registered phase outputs with programmable rise/fall positions. New
// positions are staged in shadow registers and take effect at period wrap.
module clock_phase_gen #(
  parameter int PERIOD   = 80,
  parameter int CHANNELS = 3,
  parameter int CW       = $clog2(PERIOD)
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                run,
  input  logic                step,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [CW-1:0]       cfg_rise,
  input  logic [CW-1:0]       cfg_fall,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] phi,
  output logic [CHANNELS-1:0] rise_stb,
  output logic [CHANNELS-1:0] fall_stb,
  output logic                period_stb,
  output logic                busy
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HALF = CW'(PERIOD / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          at_last;
  logic          wrap;
  logic          cfg_ok;
  logic          cfg_acc;

  logic [CW-1:0] sh_rise  [CHANNELS];
  logic [CW-1:0] sh_fall  [CHANNELS];
  logic [CW-1:0] act_rise [CHANNELS];
  logic [CW-1:0] act_fall [CHANNELS];

  assign at_last = (cnt == LAST);
  assign wrap    = busy && at_last;

  // A write is only taken when it targets an existing channel with in-range positions
  assign cfg_ok  = (int'(cfg_ch) < CHANNELS) &&
                   (int'(cfg_rise) < PERIOD) &&
                   (int'(cfg_fall) < PERIOD);
  assign cfg_acc = cfg_we && cfg_ok;

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and busy; leaving RUN/STEP only happens at the wrap cycle
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (run)       state_nxt = RUN;
        else if (step) state_nxt = STEP;
      end
      RUN: begin
        busy = 1'b1;
        if (at_last && !run) state_nxt = IDLE;
      end
      STEP: begin
        busy = 1'b1;
        if (at_last) state_nxt = run ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter advances only while busy and wraps at PERIOD-1
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)  cnt <= '0;
    else if (busy) cnt <= at_last ? '0 : cnt + CW'(1);
  end

  // Shadow/active position registers and rejected-write flag
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_rise[i]  <= '0;
        sh_fall[i]  <= HALF;
        act_rise[i] <= '0;
        act_fall[i] <= HALF;
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_acc && (cfg_ch == 3'(i))) begin
          sh_rise[i] <= cfg_rise;
          sh_fall[i] <= cfg_fall;
        end
        // Active copy uses the pre-edge shadow, so a write at wrap waits one period
        if (!busy || wrap) begin
          act_rise[i] <= sh_rise[i];
          act_fall[i] <= sh_fall[i];
        end
      end
    end
  end

  // Phase outputs and strobes; phi freezes and strobes stay low while idle
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      phi        <= '0;
      rise_stb   <= '0;
      fall_stb   <= '0;
      period_stb <= 1'b0;
    end else begin
      rise_stb   <= '0;
      fall_stb   <= '0;
      period_stb <= wrap;
      if (busy) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (act_rise[i] == act_fall[i]) begin
            phi[i] <= 1'b0;
          end else if (cnt == act_rise[i]) begin
            phi[i]      <= 1'b1;
            rise_stb[i] <= !phi[i];
          end else if (cnt == act_fall[i]) begin
            phi[i]      <= 1'b0;
            fall_stb[i] <= phi[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen (PERIOD=8, CHANNELS=3, CW=4).
// Stimulus pushes time-stamped expected strobe snapshots; a monitor pops one
// whenever the DUT shows any strobe and compares the full output snapshot.
module tb_clock_phase_gen;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       run;
  logic       step;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [3:0] cfg_rise;
  logic [3:0] cfg_fall;
  logic       cfg_err;
  logic [2:0] phi;
  logic [2:0] rise_stb;
  logic [2:0] fall_stb;
  logic       period_stb;
  logic       busy;

  clock_phase_gen #(.PERIOD(8), .CHANNELS(3), .CW(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .run       (run),
    .step      (step),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_rise  (cfg_rise),
    .cfg_fall  (cfg_fall),
    .cfg_err   (cfg_err),
    .phi       (phi),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .period_stb(period_stb),
    .busy      (busy)
  );

  typedef struct {
    int         at;
    logic [2:0] r;
    logic [2:0] f;
    logic       p;
    logic       e;
    logic [2:0] ph;
    logic       b;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Insert keeping the queue ordered by expected edge number
  task automatic push_ev(input int at, input logic [2:0] r, input logic [2:0] f,
                         input logic p, input logic e, input logic [2:0] ph, input logic b);
    ev_t ev;
    int  idx;
    ev.at = at; ev.r = r; ev.f = f; ev.p = p; ev.e = e; ev.ph = ph; ev.b = b;
    idx = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].at > at) begin
        idx = i;
        break;
      end
    end
    sbq.insert(idx, ev);
  endtask

  // All channels rise=0 fall=4; b is the edge where cnt becomes 0
  task automatic period_default(input int b, input logic lb);
    push_ev(b + 1, 3'b111, 3'b000, 1'b0, 1'b0, 3'b111, 1'b1);
    push_ev(b + 5, 3'b000, 3'b111, 1'b0, 1'b0, 3'b000, 1'b1);
    push_ev(b + 8, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, lb);
  endtask

  // ch1 rise=2 fall=6, ch0/ch2 default
  task automatic period_ch1(input int b);
    push_ev(b + 1, 3'b101, 3'b000, 1'b0, 1'b0, 3'b101, 1'b1);
    push_ev(b + 3, 3'b010, 3'b000, 1'b0, 1'b0, 3'b111, 1'b1);
    push_ev(b + 5, 3'b000, 3'b101, 1'b0, 1'b0, 3'b010, 1'b1);
    push_ev(b + 7, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1);
    push_ev(b + 8, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1);
  endtask

  // ch0 0/4, ch1 2/6, ch2 rise=5 fall=1 (high across the wrap); s2 = phi[2] at start
  task automatic period_ch12(input int b, input logic s2, input logic lb, input int upto);
    push_ev(b + 1, 3'b001, 3'b000, 1'b0, 1'b0, {s2, 2'b01}, 1'b1);
    if (s2 && upto >= 2) push_ev(b + 2, 3'b000, 3'b100, 1'b0, 1'b0, 3'b001, 1'b1);
    if (upto >= 3) push_ev(b + 3, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 1'b1);
    if (upto >= 5) push_ev(b + 5, 3'b000, 3'b001, 1'b0, 1'b0, 3'b010, 1'b1);
    if (upto >= 6) push_ev(b + 6, 3'b100, 3'b000, 1'b0, 1'b0, 3'b110, 1'b1);
    if (upto >= 7) push_ev(b + 7, 3'b000, 3'b010, 1'b0, 1'b0, 3'b100, 1'b1);
    if (upto >= 8) push_ev(b + 8, 3'b000, 3'b000, 1'b1, 1'b0, 3'b100, lb);
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [3:0] r, input logic [3:0] f);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_rise = r;
    cfg_fall = f;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Monitor: pop and compare on every cycle that shows a strobe
  initial begin
    ev_t ex;
    forever begin
      @(negedge CLOCK_50);
      if (RESET_N && ((rise_stb != 3'b000) || (fall_stb != 3'b000) || period_stb || cfg_err)) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe cyc=%0d actual r=%b f=%b p=%b e=%b phi=%b busy=%b required none",
                   cyc, rise_stb, fall_stb, period_stb, cfg_err, phi, busy);
        end else begin
          ex = sbq.pop_front();
          if ((ex.at != cyc) ||
              ({rise_stb, fall_stb, period_stb, cfg_err, phi, busy} !==
               {ex.r, ex.f, ex.p, ex.e, ex.ph, ex.b})) begin
            failures++;
            $display("FAIL event cyc=%0d actual r=%b f=%b p=%b e=%b phi=%b busy=%b required cyc=%0d r=%b f=%b p=%b e=%b phi=%b busy=%b",
                     cyc, rise_stb, fall_stb, period_stb, cfg_err, phi, busy,
                     ex.at, ex.r, ex.f, ex.p, ex.e, ex.ph, ex.b);
          end
        end
      end
    end
  end

  initial begin
    int s;
    int b0;
    int t;
    int nb;
    int u;
    int s2;

    RESET_N  = 1'b1;
    run      = 1'b1;
    step     = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 3'd0;
    cfg_rise = 4'd0;
    cfg_fall = 4'd0;
    #2 RESET_N = 1'b0;
    repeat (3) tick();

    chk("reset_phi", 32'(phi), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_strobes", 32'({rise_stb, fall_stb, period_stb, cfg_err}), 32'h0);

    // Release with run held high: RUN on first edge, first count on second
    s = cyc;
    b0 = s + 1;
    period_default(b0, 1'b1);
    period_default(b0 + 8, 1'b1);
    period_default(b0 + 16, 1'b1);
    period_ch1(b0 + 24);
    push_ev(b0 + 24 + 2, 3'b000, 3'b000, 1'b0, 1'b1, 3'b101, 1'b1);
    push_ev(b0 + 24 + 4, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 1'b1);
    period_ch1(b0 + 32);
    period_ch1(b0 + 40);
    period_ch12(b0 + 48, 1'b0, 1'b0, 8);
    RESET_N = 1'b1;

    wait_to(b0 + 16 + 2);
    cfg_write(3'd1, 4'd2, 4'd6);
    wait_to(b0 + 24 + 1);
    cfg_write(3'd5, 4'd0, 4'd0);
    wait_to(b0 + 24 + 3);
    cfg_write(3'd1, 4'd9, 4'd6);
    // Write lands on the wrap edge of period 4 -> visible from period 6
    wait_to(b0 + 32 + 7);
    cfg_write(3'd2, 4'd5, 4'd1);
    wait_to(b0 + 48 + 3);
    run = 1'b0;

    wait_to(b0 + 56 + 4);
    for (int k = 0; k < 3; k++) begin
      chk("freeze_phi", 32'(phi), 32'h4);
      chk("freeze_busy", 32'(busy), 32'h0);
      tick();
    end

    // Single step: exactly one period, extra step while busy ignored
    t = cyc;
    period_ch12(t + 1, 1'b1, 1'b0, 8);
    step = 1'b1;
    tick();
    step = 1'b0;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) nb++;
      if (k == 2) step = 1'b1;
      if (k == 3) step = 1'b0;
      tick();
    end
    chk("step_busy_cycles", 32'(nb), 32'd8);
    chk("step_idle_busy", 32'(busy), 32'h0);
    chk("step_idle_phi", 32'(phi), 32'h4);

    // Run again, then reset mid-period at cnt=5
    u = cyc;
    period_ch12(u + 1, 1'b1, 1'b1, 5);
    run = 1'b1;
    wait_to(u + 1 + 5);
    @(negedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset_phi", 32'(phi), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_strobes", 32'({rise_stb, fall_stb, period_stb, cfg_err}), 32'h0);
    tick();
    tick();
    chk("held_reset_phi", 32'(phi), 32'h0);

    // Release: defaults restored on every channel
    s2 = cyc;
    period_default(s2 + 1, 1'b1);
    period_default(s2 + 9, 1'b0);
    RESET_N = 1'b1;
    wait_to(s2 + 9 + 2);
    run = 1'b0;
    wait_to(s2 + 17 + 3);
    chk("final_busy", 32'(busy), 32'h0);
    chk("final_phi", 32'(phi), 32'h0);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_phase_gen.md
CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

Interface
REQ-001 Parameter PERIOD, default 80, base-clock cycles per output period (legal range 4..65535).
REQ-002 Parameter CHANNELS, default 3, number of phase outputs (legal range 1..8).
REQ-003 Parameter CW, default $clog2(PERIOD), width of the phase counter and position fields.
REQ-004 Port CLOCK_50  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 Port RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-006 Port run  in  1  level; 1 = free-running periods.
REQ-007 Port step  in  1  one-cycle pulse; requests exactly one period while stopped.
REQ-008 Port cfg_we  in  1  config write strobe.
REQ-009 Port cfg_ch  in  3  target channel index.
REQ-010 Port cfg_rise  in  CW  counter value at which the channel rises.
REQ-011 Port cfg_fall  in  CW  counter value at which the channel falls.
REQ-012 Port cfg_err  out  1  one-cycle pulse on a rejected write.
REQ-013 Port phi  out  CHANNELS  phase clocks, registered.
REQ-014 Port rise_stb  out  CHANNELS  one-cycle pulse, registered, coincident with the phi 0->1 transition.
REQ-015 Port fall_stb  out  CHANNELS  one-cycle pulse, registered, coincident with the phi 1->0 transition.
REQ-016 Port period_stb  out  1  one-cycle pulse in the cycle the counter wraps.
REQ-017 Port busy  out  1  high while the counter is advancing.

Function
REQ-018 Phase counter cnt SHALL count 0..PERIOD-1 and wrap to 0 while in state RUN or STEP; it SHALL hold its value in IDLE.
REQ-019 FSM states SHALL be IDLE, RUN and STEP; busy = (state != IDLE).
REQ-020 IDLE->RUN on run=1; IDLE->STEP on step=1 with run=0; run takes priority when both are asserted.
REQ-021 RUN->IDLE and STEP->IDLE SHALL occur only at wrap (cnt==PERIOD-1): from RUN when run=0, from STEP unless run=1 (in which case STEP->RUN).
REQ-022 A step pulse received while busy SHALL be ignored.
REQ-023 Each channel i SHALL hold active positions act_rise[i] and act_fall[i].
REQ-024 While busy, on the edge following a cycle with cnt==act_rise[i], phi[i] SHALL be 1 and rise_stb[i] SHALL pulse if phi[i] was 0.
REQ-025 While busy, on the edge following a cycle with cnt==act_fall[i], phi[i] SHALL be 0 and fall_stb[i] SHALL pulse if phi[i] was 1.
REQ-026 If act_rise[i]==act_fall[i], phi[i] SHALL be held at 0 and neither strobe for channel i SHALL pulse.
REQ-027 In IDLE, phi SHALL hold its last value and all strobes SHALL be 0.
REQ-028 An accepted write (cfg_we=1, cfg_ch<CHANNELS, cfg_rise<PERIOD, cfg_fall<PERIOD) SHALL update shadow registers only.
REQ-029 Shadow values SHALL be copied into the active registers at wrap, and immediately when in IDLE, so one period never mixes configurations.
REQ-030 A rejected write SHALL leave all registers unchanged and pulse cfg_err on the next cycle.
REQ-031 A write in the same cycle as a wrap SHALL be applied at the following wrap.
REQ-032 Multiple writes to the same channel before a wrap SHALL resolve last-write-wins.
REQ-033 period_stb SHALL be registered, asserting on the edge after the cycle with cnt==PERIOD-1.

Reset
REQ-034 While RESET_N=0, outputs SHALL be: state=IDLE, cnt=0, phi=0, all strobes 0, cfg_err=0, busy=0.
REQ-035 While RESET_N=0, for every channel shadow and active rise SHALL be 0 and fall SHALL be PERIOD/2.
REQ-036 Reset asserted mid-period SHALL take effect immediately without waiting for a clock; release SHALL be sampled synchronously, with the first count on the second edge after release.

Verification
REQ-037 PERIOD=8, CHANNELS=3, reset defaults, run=1 -> every phi is high for 4 cycles and low for 4; period_stb every 8 cycles; rise_stb aligned with each phi rise.
REQ-038 Write ch1 rise=2 fall=6 mid-period -> current period unchanged; from next period phi[1] rises 3 cycles and falls 7 cycles after each wrap cycle.
REQ-039 Writes with cfg_ch=5 and cfg_rise=9 -> one cfg_err pulse each; phi waveform unchanged.
REQ-040 run=0, single step pulse -> exactly 8 busy cycles, one period_stb, then IDLE with cnt=0; second step pulse while busy is ignored.
REQ-041 run dropped at cnt=3 -> counting continues to 7, wraps, then IDLE; phi frozen thereafter.
REQ-042 RESET_N low at cnt=5 -> phi=0 and busy=0 without a clock edge; after release, defaults are restored.
